counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
- Sequencing controller for the catalog's N-bit up/down counter datapath. Turns it into a programmable interval timer.
- Latches a configuration (terminal value, direction, one-shot/periodic, prescale) through a valid/ready handshake.
- Runs the count under start/stop commands and emits a one-cycle terminal tick.
- Sits between a control agent (CPU-side register block or FSM) and any logic that needs periodic or delayed events.

Parameters:
- N, 8, count/limit width in bits
- PW, 4, prescale field width; count advances once every (prescale+1) clk cycles

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous active-low reset
- cfg_valid  input  1  configuration offered
- cfg_ready  output  1  controller can accept configuration
- cfg_limit  input  N  terminal value
- cfg_dir  input  1  1 = count up (0 to limit), 0 = count down (limit to 0)
- cfg_periodic  input  1  1 = auto-reload, 0 = one-shot
- cfg_prescale  input  PW  step divider
- start  input  1  begin counting (single-cycle pulse or level; sampled per cycle)
- stop  input  1  abort counting
- count  output  N  current count value
- busy  output  1  high while in RUN
- tick  output  1  one-cycle pulse on each terminal event
- done  output  1  level; one-shot run completed

Behaviour:
- Reset (rst=0, asynchronous, also mid-run): state=IDLE, count=0, busy=0, tick=0, done=0, cfg_ready=1, latched limit=0, dir=1, periodic=0, prescale=0, prescale counter=0.
- States:
  - IDLE: not running; cfg_ready=1, busy=0.
  - RUN: busy=1, cfg_ready=0.
  - DONE: one-shot finished; cfg_ready=1, busy=0, done=1.
- Config: accepted on posedge when cfg_valid and cfg_ready. Values latch; count is unchanged. cfg_valid in RUN is ignored, and the source must hold it until ready.
- Start from IDLE or DONE:
  - Next state RUN, done<=0, prescale counter<=0.
  - count<=0 if dir=1, else count<=limit.
  - If config and start occur in the same cycle, start uses the newly offered config values.
  - Start while in RUN is ignored.
- Step timing in RUN: the prescale counter increments each cycle. When it equals the latched prescale, it wraps to 0 and a step occurs. The first step comes (prescale+1) cycles after entering RUN.
- Step at non-terminal count: count<=count+1 (dir=1) or count-1 (dir=0), arithmetic modulo 2^N.
- Step at terminal count (count==limit when up, count==0 when down):
  - tick<=1 for exactly one cycle.
  - Periodic: count reloads its start value (0 when up, limit when down) and stays in RUN.
  - One-shot: count holds the terminal value, state<=DONE, done<=1.
- Period: (limit+1)*(prescale+1) cycles between ticks. limit=0 gives a tick on every step.
- Stop in RUN: state<=IDLE, count held, busy<=0, no tick. Stop in IDLE/DONE: no effect (done stays).
- Start and stop in the same cycle: stop wins (from RUN, go to IDLE; from IDLE/DONE, no start).
- Stop coinciding with a terminal step: stop wins, so no tick and no reload.
- Outputs are registered. No combinational path from inputs to count/tick/busy/done. cfg_ready depends on state only.

Test Plan:
- Reset mid-RUN (count=5) -> count=0, busy=0, tick=0, done=0, cfg_ready=1 immediately, without waiting for clk.
- Config limit=3, dir=1, periodic=1, prescale=0, then start -> count sequence 0,1,2,3,0,1..., tick high for one cycle each time count returns to 0, ticks every 4 cycles.
- Config limit=2, dir=0, periodic=0, prescale=1, then start -> count 2,2,1,1,0,0 then holds 0; single tick; done=1, busy=0, cfg_ready=1.
- Periodic run with limit=5 -> stop at count=3 gives count held at 3, busy=0, no tick. Start and stop in the same cycle from IDLE keeps busy=0.
- cfg_valid with new limit during RUN -> cfg_ready=0 and the run is unaffected. After stop, the handshake completes and the next start counts to the new limit.
- N=8, limit=255, dir=1, prescale=0 -> count reaches 255, tick fires, count wraps to 0. Limit=0 with dir=1 -> tick every cycle.

Source files
------------

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl
// Description : Programmable interval timer controller. Latches terminal value,
//               direction, reload mode and prescale through a valid/ready
//               handshake, then steps an N-bit up/down count under start/stop
//               control and emits a one-cycle tick on each terminal event.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [N-1:0]  cfg_limit,
  input  logic          cfg_dir,
  input  logic          cfg_periodic,
  input  logic [PW-1:0] cfg_prescale,
  input  logic          start,
  input  logic          stop,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic          tick,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_count, w_count_nxt;
  logic [N-1:0]  r_limit, w_limit_nxt;
  logic          r_dir, w_dir_nxt;
  logic          r_periodic, w_periodic_nxt;
  logic [PW-1:0] r_prescale, w_prescale_nxt;
  logic [PW-1:0] r_pcnt, w_pcnt_nxt;
  logic          r_tick, w_tick_nxt;

  logic          w_cfg_acc;
  logic [N-1:0]  w_limit_eff;
  logic          w_dir_eff;
  logic          w_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_limit    <= '0;
      r_dir      <= 1'b1;
      r_periodic <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_limit    <= w_limit_nxt;
      r_dir      <= w_dir_nxt;
      r_periodic <= w_periodic_nxt;
      r_prescale <= w_prescale_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_tick     <= w_tick_nxt;
    end
  end

  // A start coinciding with a config transfer must use the offered values.
  assign w_cfg_acc   = cfg_valid && (r_state != S_RUN);
  assign w_limit_eff = w_cfg_acc ? cfg_limit : r_limit;
  assign w_dir_eff   = w_cfg_acc ? cfg_dir   : r_dir;
  assign w_term      = r_dir ? (r_count == r_limit) : (r_count == '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_limit_nxt    = r_limit;
    w_dir_nxt      = r_dir;
    w_periodic_nxt = r_periodic;
    w_prescale_nxt = r_prescale;
    w_pcnt_nxt     = r_pcnt;
    w_tick_nxt     = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_cfg_acc) begin
          w_limit_nxt    = cfg_limit;
          w_dir_nxt      = cfg_dir;
          w_periodic_nxt = cfg_periodic;
          w_prescale_nxt = cfg_prescale;
        end
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_pcnt_nxt  = '0;
          w_count_nxt = w_dir_eff ? '0 : w_limit_eff;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_pcnt == r_prescale) begin
          w_pcnt_nxt = '0;
          if (w_term) begin
            w_tick_nxt = 1'b1;
            if (r_periodic) begin
              w_count_nxt = r_dir ? '0 : r_limit;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_count_nxt = r_dir ? (r_count + 1'b1) : (r_count - 1'b1);
          end
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign count     = r_count;
  assign tick      = r_tick;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign cfg_ready = (r_state != S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_counter_ctrl
// Description : Directed self-checking bench for counter_ctrl with a
//               closed-form timer model compared on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;
  localparam int N  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_dir = 1'b0;
  logic          cfg_periodic = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [N-1:0]  cfg_limit = '0;
  logic [PW-1:0] cfg_prescale = '0;
  logic          cfg_ready, busy, tick, done;
  logic [N-1:0]  count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: run time since start, from which the count follows directly.
  bit m_run = 1'b0, m_done = 1'b0, m_tick = 1'b0, m_dir = 1'b1, m_per = 1'b0;
  int m_lim = 0, m_psc = 0, m_k = 0, m_count = 0, m_s = 0, m_r = 0;

  int exp_b[8] = '{2, 2, 1, 1, 0, 0, 0, 0};

  always #5 clk = ~clk;

  counter_ctrl #(.N(N), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_limit(cfg_limit), .cfg_dir(cfg_dir),
    .cfg_periodic(cfg_periodic), .cfg_prescale(cfg_prescale),
    .start(start), .stop(stop),
    .count(count), .busy(busy), .tick(tick), .done(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int lim, input bit dir, input bit per, input int psc);
    cfg_valid    = 1'b1;
    cfg_limit    = lim[N-1:0];
    cfg_dir      = dir;
    cfg_periodic = per;
    cfg_prescale = psc[PW-1:0];
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_done = 0; m_tick = 0; m_dir = 1; m_per = 0;
      m_lim = 0; m_psc = 0; m_k = 0; m_count = 0;
    end else begin
      m_tick = 0;
      if (!m_run) begin
        if (cfg_valid) begin
          m_lim = cfg_limit; m_dir = cfg_dir; m_per = cfg_periodic; m_psc = cfg_prescale;
        end
        if (start && !stop) begin
          m_run = 1; m_done = 0; m_k = 0;
          m_count = m_dir ? 0 : m_lim;
        end
      end else if (stop) begin
        m_run = 0;
      end else begin
        m_k++;
        if (m_k % (m_psc + 1) == 0) begin
          m_s = m_k / (m_psc + 1);
          m_r = m_s % (m_lim + 1);
          if (m_r == 0) begin
            m_tick = 1;
            if (m_per) m_count = m_dir ? 0 : m_lim;
            else begin
              m_count = m_dir ? m_lim : 0;
              m_run = 0; m_done = 1;
            end
          end else begin
            m_count = m_dir ? m_r : m_lim - m_r;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("mdl_count", count, m_count);
      chk("mdl_tick", tick, m_tick);
      chk("mdl_busy", busy, m_run);
      chk("mdl_done", done, m_done);
      chk("mdl_ready", cfg_ready, !m_run);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // periodic up, limit 3, config and start together
    set_cfg(3, 1, 1, 0); start = 1;
    @(negedge clk); cfg_valid = 0; start = 0;
    chk("A_cnt0", count, 0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("A_cnt", count, i % 4);
      chk("A_tick", tick, int'(i % 4 == 0));
    end
    stop = 1; @(negedge clk); stop = 0;
    chk("A_stop_busy", busy, 0);

    // one-shot down, limit 2, prescale 1
    set_cfg(2, 0, 0, 1);
    @(negedge clk); cfg_valid = 0; start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("B_cnt", count, exp_b[i]);
      chk("B_tick", tick, int'(i == 6));
      chk("B_done", done, int'(i >= 6));
    end
    chk("B_ready", cfg_ready, 1);
    chk("B_busy", busy, 0);

    // periodic limit 5, stop at count 3
    set_cfg(5, 1, 1, 0); start = 1;
    @(negedge clk); cfg_valid = 0; start = 0;
    chk("C_done_clr", done, 0);
    repeat (3) @(negedge clk);
    chk("C_cnt3", count, 3);
    stop = 1; @(negedge clk); stop = 0;
    chk("C_hold", count, 3);
    chk("C_busy", busy, 0);
    chk("C_tick", tick, 0);
    start = 1; stop = 1; @(negedge clk); start = 0; stop = 0;
    chk("C_ss_busy", busy, 0);
    chk("C_ss_cnt", count, 3);

    // config offered during RUN is held off until the run stops
    start = 1; @(negedge clk); start = 0;
    set_cfg(2, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("D_ready_run", cfg_ready, 0);
    chk("D_cnt", count, 3);
    stop = 1; @(negedge clk); stop = 0;
    chk("D_hold", count, 3);
    @(negedge clk); cfg_valid = 0; start = 1;
    @(negedge clk); start = 0;
    chk("D_cnt0", count, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("D_cnt", count, i % 3);
      chk("D_tick", tick, int'(i == 3));
    end
    stop = 1; @(negedge clk); stop = 0;

    // full-range wrap at limit 255
    set_cfg(255, 1, 1, 0); start = 1;
    @(negedge clk); cfg_valid = 0; start = 0;
    repeat (255) @(negedge clk);
    chk("E_cnt255", count, 255);
    chk("E_tick0", tick, 0);
    @(negedge clk);
    chk("E_wrap", count, 0);
    chk("E_tick", tick, 1);
    stop = 1; @(negedge clk); stop = 0;

    // limit 0 ticks every step; stop on a terminal step suppresses the tick
    set_cfg(0, 1, 1, 0); start = 1;
    @(negedge clk); cfg_valid = 0; start = 0;
    chk("L0_tick0", tick, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("L0_tick", tick, 1);
      chk("L0_cnt", count, 0);
    end
    stop = 1; @(negedge clk); stop = 0;
    chk("L0_stop_tick", tick, 0);
    chk("L0_stop_busy", busy, 0);

    // asynchronous reset mid-run
    set_cfg(9, 1, 1, 0); start = 1;
    @(negedge clk); cfg_valid = 0; start = 0;
    repeat (5) @(negedge clk);
    chk("F_cnt5", count, 5);
    #2 rst = 1'b0;
    #1;
    chk("F_cnt", count, 0);
    chk("F_busy", busy, 0);
    chk("F_tick", tick, 0);
    chk("F_done", done, 0);
    chk("F_ready", cfg_ready, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("F_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
